// File: rtl/gemm_layer_sched_pkg.sv
// Shared definitions for the NPU layer scheduler: FSM states, defaults and
// the lane-count to byte-enable helper.
package npu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } sched_state_e;

  localparam int unsigned TIMEOUT_DEFAULT      = 4096;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 16;
  localparam int unsigned LANES_PER_BEAT       = 8;
  localparam int unsigned GROUP_WIDTH          = 3;

  // A group count of zero means a full beat; otherwise the low 'groups'
  // lanes are valid.
  function automatic logic [LANES_PER_BEAT-1:0] lanes_to_be(
    input logic [GROUP_WIDTH-1:0] groups
  );
    logic [LANES_PER_BEAT-1:0] be;
    int unsigned               lanes;
    lanes = (groups == '0) ? LANES_PER_BEAT : 32'(groups);
    be    = '0;
    for (int unsigned k = 0; k < LANES_PER_BEAT; k++) begin
      be[k] = (k < lanes);
    end
    return be;
  endfunction

endpackage

// File: rtl/gemm_layer_sched_out_writeback.sv
// Output write-back: beat/address counter, byte-enable generation and the
// registered SRAM write port.
module out_writeback
  import npu_sched_pkg::*;
#(
  parameter int unsigned MAX_ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_LANES      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic [MAX_ADDR_WIDTH-1:0]       i_base,
  input  logic                            i_fire,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] i_data,
  input  logic [GROUP_WIDTH-1:0]          i_groups,
  output logic [MAX_ADDR_WIDTH-1:0]       o_beat_cnt,
  output logic                            o_wr_en,
  output logic [MAX_ADDR_WIDTH-1:0]       o_wr_addr,
  output logic [DATA_WIDTH*NUM_LANES-1:0] o_wr_data,
  output logic [NUM_LANES-1:0]            o_wr_be
);

  logic [MAX_ADDR_WIDTH-1:0]       r_beat_cnt;
  logic                            r_wr_en;
  logic [MAX_ADDR_WIDTH-1:0]       r_wr_addr;
  logic [DATA_WIDTH*NUM_LANES-1:0] r_wr_data;
  logic [NUM_LANES-1:0]            r_wr_be;

  logic [MAX_ADDR_WIDTH-1:0]       w_addr;
  logic [NUM_LANES-1:0]            w_be;

  // Address wraps naturally at the counter width.
  assign w_addr = i_base + r_beat_cnt;
  assign w_be   = lanes_to_be(i_groups);

  // Beat counter: cleared per command, advanced once per accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (i_clear) begin
      r_beat_cnt <= '0;
    end else if (i_fire) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  // Write register: one-cycle strobe, payload held between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else begin
      r_wr_en <= i_fire;
      if (i_fire) begin
        r_wr_addr <= w_addr;
        r_wr_data <= i_data;
        r_wr_be   <= w_be;
      end
    end
  end

  assign o_beat_cnt = r_beat_cnt;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_be    = r_wr_be;

endmodule

// File: rtl/gemm_layer_sched.sv
// Layer scheduler in front of the GEMM datapath: command latch, layer FSM,
// stall watchdog and abort flush, with beat write-back delegated to
// out_writeback.
module gemm_layer_sched
  import npu_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned MAX_ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_LANES      = 8,
  parameter int unsigned TIMEOUT        = TIMEOUT_DEFAULT,
  parameter int unsigned FLUSH_CYCLES   = FLUSH_CYCLES_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  // command
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [ADDR_WIDTH-1:0]           cmd_img_row,
  input  logic [ADDR_WIDTH-1:0]           cmd_img_col,
  input  logic [ADDR_WIDTH-1:0]           cmd_ker_row,
  input  logic [ADDR_WIDTH-1:0]           cmd_ker_col,
  input  logic [ADDR_WIDTH-1:0]           cmd_in_ch,
  input  logic [ADDR_WIDTH-1:0]           cmd_out_ch,
  input  logic [3:0]                      cmd_stride_h,
  input  logic [3:0]                      cmd_stride_w,
  input  logic                            cmd_padding,
  input  logic [31:0]                     cmd_qmult,
  input  logic signed [31:0]              cmd_shift,
  input  logic [MAX_ADDR_WIDTH-1:0]       cmd_out_base,
  input  logic [MAX_ADDR_WIDTH-1:0]       cmd_out_beats,
  // configuration to GEMM
  output logic [ADDR_WIDTH-1:0]           cfg_img_row,
  output logic [ADDR_WIDTH-1:0]           cfg_img_col,
  output logic [ADDR_WIDTH-1:0]           cfg_ker_row,
  output logic [ADDR_WIDTH-1:0]           cfg_ker_col,
  output logic [ADDR_WIDTH-1:0]           cfg_in_ch,
  output logic [ADDR_WIDTH-1:0]           cfg_out_ch,
  output logic [3:0]                      cfg_stride_h,
  output logic [3:0]                      cfg_stride_w,
  output logic                            cfg_padding,
  output logic [31:0]                     cfg_qmult,
  output logic signed [31:0]              cfg_shift,
  output logic                            conv_en_o,
  // returns from GEMM
  input  logic                            rq_valid_i,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] rq_data_i,
  input  logic [GROUP_WIDTH-1:0]          rq_groups_i,
  // output SRAM write port
  output logic                            wr_en,
  output logic [MAX_ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH*NUM_LANES-1:0] wr_data,
  output logic [NUM_LANES-1:0]            wr_be,
  // control / status
  input  logic                            abort_i,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);

  sched_state_e r_state, w_next_state;

  logic [MAX_ADDR_WIDTH-1:0] r_out_base;
  logic [MAX_ADDR_WIDTH-1:0] r_out_beats;
  logic [WD_W-1:0]           r_wdog;
  logic [FL_W-1:0]           r_flush_cnt;
  logic                      r_err;

  logic [MAX_ADDR_WIDTH-1:0] w_beat_cnt;
  logic                      w_accept;
  logic                      w_fire;
  logic                      w_last;
  logic                      w_timeout;
  logic                      w_stray;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  // Abort takes precedence over any beat in the same cycle.
  assign w_fire    = (r_state == ST_RUN) && rq_valid_i && !abort_i;
  assign w_last    = w_fire && (w_beat_cnt == (r_out_beats - 1'b1));
  assign w_timeout = (r_state == ST_RUN) && !abort_i && !rq_valid_i &&
                     (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_stray   = (r_state == ST_IDLE) && rq_valid_i;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    conv_en_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_i)                 w_next_state = ST_FLUSH;
        else if (r_out_beats == '0)  w_next_state = ST_DONE;
        else                         w_next_state = ST_RUN;
      end
      ST_RUN: begin
        conv_en_o = 1'b1;
        if (abort_i)        w_next_state = ST_FLUSH;
        else if (w_last)    w_next_state = ST_DONE;
        else if (w_timeout) w_next_state = ST_FLUSH;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FL_W'(FLUSH_CYCLES - 1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Command latch: configuration held stable until the next accepted command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_img_row  <= '0;
      cfg_img_col  <= '0;
      cfg_ker_row  <= '0;
      cfg_ker_col  <= '0;
      cfg_in_ch    <= '0;
      cfg_out_ch   <= '0;
      cfg_stride_h <= '0;
      cfg_stride_w <= '0;
      cfg_padding  <= 1'b0;
      cfg_qmult    <= '0;
      cfg_shift    <= '0;
      r_out_base   <= '0;
      r_out_beats  <= '0;
    end else if (w_accept) begin
      cfg_img_row  <= cmd_img_row;
      cfg_img_col  <= cmd_img_col;
      cfg_ker_row  <= cmd_ker_row;
      cfg_ker_col  <= cmd_ker_col;
      cfg_in_ch    <= cmd_in_ch;
      cfg_out_ch   <= cmd_out_ch;
      cfg_stride_h <= cmd_stride_h;
      cfg_stride_w <= cmd_stride_w;
      cfg_padding  <= cmd_padding;
      cfg_qmult    <= cmd_qmult;
      cfg_shift    <= cmd_shift;
      r_out_base   <= cmd_out_base;
      r_out_beats  <= cmd_out_beats;
    end
  end

  // Watchdog: counts RUN cycles since the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (w_accept) begin
      r_wdog <= '0;
    end else if (r_state == ST_RUN) begin
      if (rq_valid_i) r_wdog <= '0;
      else            r_wdog <= r_wdog + 1'b1;
    end
  end

  // Flush timer: runs only while in FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end else begin
      r_flush_cnt <= '0;
    end
  end

  // Sticky error: stray beat in IDLE or watchdog expiry; new command clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_stray || w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  out_writeback #(
    .MAX_ADDR_WIDTH (MAX_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_LANES      (NUM_LANES)
  ) u_out_writeback (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_base     (r_out_base),
    .i_fire     (w_fire),
    .i_data     (rq_data_i),
    .i_groups   (rq_groups_i),
    .o_beat_cnt (w_beat_cnt),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_wr_be    (wr_be)
  );

endmodule

// File: tb/tb_gemm_layer_sched.sv
// Directed/randomized bench for gemm_layer_sched with timing-level expectations.
module tb_gemm_layer_sched;

  localparam int unsigned TMO = 4096;
  localparam int unsigned FLC = 16;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [12:0] cmd_img_row, cmd_img_col, cmd_ker_row, cmd_ker_col, cmd_in_ch, cmd_out_ch;
  logic [3:0]  cmd_stride_h, cmd_stride_w;
  logic        cmd_padding;
  logic [31:0] cmd_qmult;
  logic signed [31:0] cmd_shift;
  logic [17:0] cmd_out_base, cmd_out_beats;
  logic [12:0] cfg_img_row, cfg_img_col, cfg_ker_row, cfg_ker_col, cfg_in_ch, cfg_out_ch;
  logic [3:0]  cfg_stride_h, cfg_stride_w;
  logic        cfg_padding;
  logic [31:0] cfg_qmult;
  logic signed [31:0] cfg_shift;
  logic        conv_en_o;
  logic        rq_valid_i;
  logic [63:0] rq_data_i;
  logic [2:0]  rq_groups_i;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        abort_i, busy, done, err;

  int checks = 0;
  int errors = 0;
  logic saw_done;

  gemm_layer_sched #(
    .TIMEOUT      (TMO),
    .FLUSH_CYCLES (FLC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_img_row(cmd_img_row), .cmd_img_col(cmd_img_col),
    .cmd_ker_row(cmd_ker_row), .cmd_ker_col(cmd_ker_col),
    .cmd_in_ch(cmd_in_ch), .cmd_out_ch(cmd_out_ch),
    .cmd_stride_h(cmd_stride_h), .cmd_stride_w(cmd_stride_w),
    .cmd_padding(cmd_padding), .cmd_qmult(cmd_qmult), .cmd_shift(cmd_shift),
    .cmd_out_base(cmd_out_base), .cmd_out_beats(cmd_out_beats),
    .cfg_img_row(cfg_img_row), .cfg_img_col(cfg_img_col),
    .cfg_ker_row(cfg_ker_row), .cfg_ker_col(cfg_ker_col),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .cfg_stride_h(cfg_stride_h), .cfg_stride_w(cfg_stride_w),
    .cfg_padding(cfg_padding), .cfg_qmult(cfg_qmult), .cfg_shift(cfg_shift),
    .conv_en_o(conv_en_o),
    .rq_valid_i(rq_valid_i), .rq_data_i(rq_data_i), .rq_groups_i(rq_groups_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .abort_i(abort_i), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) saw_done = 1'b1;
  endtask

  // Reference byte enable: low 'lanes' bits set, groups==0 means all eight.
  function automatic logic [7:0] ref_be(input logic [2:0] g);
    int unsigned lanes;
    lanes = (g == 3'd0) ? 8 : int'(g);
    return 8'((1 << lanes) - 1);
  endfunction

  // Accept a command and step through LOAD; checks cfg and the T+1/T+2 timing.
  task automatic send_cmd(input logic [17:0] base, input logic [17:0] beats);
    logic [12:0] e_row, e_kcol;
    logic [31:0] e_qm;
    logic signed [31:0] e_sh;
    logic [3:0]  e_sw;
    e_row = 13'($urandom); e_kcol = 13'($urandom);
    e_qm = $urandom; e_sh = $urandom; e_sw = 4'($urandom);
    cmd_img_row = e_row; cmd_img_col = 13'($urandom); cmd_ker_row = 13'($urandom);
    cmd_ker_col = e_kcol; cmd_in_ch = 13'($urandom); cmd_out_ch = 13'($urandom);
    cmd_stride_h = 4'($urandom); cmd_stride_w = e_sw; cmd_padding = 1'($urandom);
    cmd_qmult = e_qm; cmd_shift = e_sh;
    cmd_out_base = base; cmd_out_beats = beats;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", cmd_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("conv_en_in_load", conv_en_o, 0);
    chk("err_cleared_by_cmd", err, 0);
    chk("cfg_img_row", cfg_img_row, e_row);
    chk("cfg_ker_col", cfg_ker_col, e_kcol);
    chk("cfg_stride_w", cfg_stride_w, e_sw);
    chk("cfg_qmult", cfg_qmult, e_qm);
    chk("cfg_shift", cfg_shift, e_sh);
    // scramble command inputs; cfg must not follow
    cmd_img_row = ~e_row; cmd_qmult = ~e_qm;
    tick();
    if (beats == 18'd0) begin
      chk("zero_beat_done", done, 1);
      chk("zero_beat_conv_en", conv_en_o, 0);
    end else begin
      chk("conv_en_rise", conv_en_o, 1);
      chk("cfg_held", cfg_img_row, e_row);
    end
  endtask

  // One beat; checks the registered write that follows it.
  task automatic beat(input logic [63:0] data, input logic [2:0] g, input logic ab,
                      input logic exp_wr, input logic [17:0] exp_addr);
    rq_valid_i = 1'b1; rq_data_i = data; rq_groups_i = g; abort_i = ab;
    tick();
    rq_valid_i = 1'b0; abort_i = 1'b0;
    chk("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_data", wr_data, data);
      chk("wr_be", wr_be, ref_be(g));
    end
  endtask

  // Run a whole layer with random gaps, data and groups.
  task automatic layer(input logic [17:0] base, input int unsigned nb);
    logic [63:0] d;
    logic [2:0]  g;
    send_cmd(base, 18'(nb));
    for (int unsigned i = 0; i < nb; i++) begin
      for (int unsigned gp = $urandom_range(0, 2); gp > 0; gp--) begin
        tick();
        chk("gap_no_write", wr_en, 0);
      end
      d = {$urandom, $urandom};
      g = 3'($urandom);
      beat(d, g, 1'b0, 1'b1, 18'(base + 18'(i)));
      chk("done_on_last", done, (i == nb - 1) ? 1 : 0);
    end
    tick();
    chk("ready_after_done", cmd_ready, 1);
    chk("done_one_cycle", done, 0);
    chk("wr_en_one_wide", wr_en, 0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; rq_valid_i = 1'b0; abort_i = 1'b0;
    rq_data_i = '0; rq_groups_i = '0; saw_done = 1'b0;
    cmd_img_row = '0; cmd_img_col = '0; cmd_ker_row = '0; cmd_ker_col = '0;
    cmd_in_ch = '0; cmd_out_ch = '0; cmd_stride_h = '0; cmd_stride_w = '0;
    cmd_padding = 1'b0; cmd_qmult = '0; cmd_shift = '0;
    cmd_out_base = '0; cmd_out_beats = '0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_conv_en", conv_en_o, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_be", wr_be, 0);
    chk("rst_cfg_qmult", cfg_qmult, 0);
    rst = 1'b1;
    tick();

    // basic layer: base 0x100, 4 back-to-back full beats
    send_cmd(18'h100, 18'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      beat({$urandom, $urandom}, 3'd0, 1'b0, 1'b1, 18'(18'h100 + 18'(i)));
      chk("basic_done", done, (i == 3) ? 1 : 0);
      chk("basic_conv_en", conv_en_o, (i == 3) ? 0 : 1);
    end
    tick();
    chk("basic_ready", cmd_ready, 1);

    // partial lanes
    send_cmd(18'h2000, 18'd1);
    beat(64'h0000_0000_00AA_BBCC, 3'd3, 1'b0, 1'b1, 18'h2000);
    chk("partial_be_07", wr_be, 8'h07);
    tick();

    // randomized layers
    for (int l = 0; l < 6; l++) layer(18'($urandom), $urandom_range(1, 6));

    // address wrap
    layer(18'h3FFFE, 3);

    // zero-beat command
    send_cmd(18'h55, 18'd0);
    tick();
    chk("zero_ready", cmd_ready, 1);
    chk("zero_done_low", done, 0);

    // stray beat in IDLE
    beat(64'hDEAD_BEEF, 3'd0, 1'b0, 1'b0, 18'd0);
    chk("stray_err", err, 1);
    chk("stray_busy", busy, 0);

    // command ignored while busy; stray err cleared by accept
    send_cmd(18'h10, 18'd2);
    begin
      logic [12:0] row_hold;
      row_hold = cfg_img_row;
      cmd_valid = 1'b1; cmd_img_row = ~row_hold;
      tick();
      cmd_valid = 1'b0;
      chk("busy_cmd_ignored", cfg_img_row, row_hold);
      chk("busy_ready_low", cmd_ready, 0);
    end
    beat(64'h1, 3'd1, 1'b0, 1'b1, 18'h10);
    beat(64'h2, 3'd2, 1'b0, 1'b1, 18'h11);
    chk("resume_done", done, 1);
    tick();

    // watchdog: TMO beatless RUN cycles
    saw_done = 1'b0;
    send_cmd(18'h40, 18'd2);
    for (int unsigned i = 0; i < TMO - 1; i++) tick();
    chk("wd_not_yet_err", err, 0);
    chk("wd_not_yet_conv", conv_en_o, 1);
    tick();
    chk("wd_err", err, 1);
    chk("wd_conv_low", conv_en_o, 0);
    chk("wd_busy", busy, 1);
    beat(64'h77, 3'd0, 1'b0, 1'b0, 18'd0);
    for (int unsigned i = 1; i < FLC - 1; i++) tick();
    chk("wd_flush_busy", cmd_ready, 0);
    tick();
    chk("wd_flush_ready", cmd_ready, 1);
    chk("wd_err_sticky", err, 1);
    chk("wd_no_done", saw_done, 0);

    // abort collides with the final beat
    saw_done = 1'b0;
    send_cmd(18'h300, 18'd3);
    beat(64'hA0, 3'd0, 1'b0, 1'b1, 18'h300);
    beat(64'hA1, 3'd0, 1'b0, 1'b1, 18'h301);
    beat(64'hA2, 3'd0, 1'b1, 1'b0, 18'd0);
    chk("abort_conv_low", conv_en_o, 0);
    chk("abort_busy", busy, 1);
    for (int unsigned i = 0; i < FLC - 1; i++) tick();
    chk("abort_flush_busy", cmd_ready, 0);
    tick();
    chk("abort_ready", cmd_ready, 1);
    chk("abort_no_done", saw_done, 0);

    // abort during LOAD
    saw_done = 1'b0;
    cmd_out_beats = 18'd5; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("load_abort_conv", conv_en_o, 0);
    chk("load_abort_busy", busy, 1);
    for (int unsigned i = 0; i < FLC; i++) tick();
    chk("load_abort_ready", cmd_ready, 1);
    chk("load_abort_no_done", saw_done, 0);

    // asynchronous reset mid-layer
    saw_done = 1'b0;
    send_cmd(18'h500, 18'd5);
    beat(64'hB0, 3'd0, 1'b0, 1'b1, 18'h500);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_conv", conv_en_o, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_cfg_row", cfg_img_row, 0);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("arst_no_done", saw_done, 0);
    chk("arst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_layer_sched.md
# gemm_layer_sched

Layer-level scheduler sitting in front of the GEMM datapath. It accepts one convolution layer command over a valid/ready handshake and holds the layer configuration stable on the GEMM inputs while `conv_en_o` is high. It counts requantized output beats returned by GEMM and writes each 64-bit beat to the output SRAM with a per-lane byte enable. It signals completion, abort or stall-timeout back to the host control path.

## Interface
- `ADDR_WIDTH`, 13, width of layer geometry fields
- `MAX_ADDR_WIDTH`, 18, width of output SRAM address and beat count
- `DATA_WIDTH`, 8, requantized lane width
- `NUM_LANES`, 8, lanes per output beat
- `TIMEOUT`, 4096, max RUN cycles without a beat before error
- `FLUSH_CYCLES`, 16, beats swallowed after abort

Ports:
- **Clock and reset (already decided):** one clock; reset is asynchronous and active-low.
  - `clk`, in, 1, clock
  - `rst`, in, 1, asynchronous active-low reset
- **Command interface:**
  - `cmd_valid`, in, 1, command present
  - `cmd_ready`, out, 1, high only in IDLE
  - `cmd_img_row`, `cmd_img_col`, `cmd_ker_row`, `cmd_ker_col`, `cmd_in_ch`, `cmd_out_ch`, in, ADDR_WIDTH each, layer geometry
  - `cmd_stride_h`, `cmd_stride_w`, in, 4 each, strides
  - `cmd_padding`, in, 1, padding enable
  - `cmd_qmult`, in, 32, quantized multiplier
  - `cmd_shift`, in, 32 signed, requant shift
  - `cmd_out_base`, in, MAX_ADDR_WIDTH, first output word address
  - `cmd_out_beats`, in, MAX_ADDR_WIDTH, number of output beats expected
- **Configuration to GEMM:**
  - `cfg_*`, out, same widths as `cmd_*` (excluding base/beats), registered copies to GEMM
  - `conv_en_o`, out, 1, GEMM convolution enable
- **Returns from GEMM:**
  - `rq_valid_i`, in, 1, requant beat valid
  - `rq_data_i`, in, 64, eight int8 lanes, lane 0 in [7:0]
  - `rq_groups_i`, in, 3, valid lane count; 0 means 8
- **Output SRAM write port:**
  - `wr_en`, out, 1, write strobe
  - `wr_addr`, out, MAX_ADDR_WIDTH, write address
  - `wr_data`, out, 64, write data
  - `wr_be`, out, 8, byte enable
- **Status:**
  - `busy`, out, 1, state ≠ IDLE
  - `done`, out, 1, one-cycle completion pulse
  - `err`, out, 1, sticky timeout/unexpected-beat flag; cleared by next accepted command

## Operation
- **States:** IDLE, LOAD, RUN, DONE, FLUSH.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch all fields, reset beat counter and watchdog, go to LOAD.
  - A `rq_valid_i` arriving in IDLE sets `err` and is not written.
- **LOAD** (1 cycle)
  - `cfg_*` already stable.
  - If `cmd_out_beats`==0, go to DONE; else go to RUN.
- **RUN**
  - `conv_en_o`=1.
  - Each `rq_valid_i` produces one write: `wr_addr`=base+beat_cnt, `wr_data`=`rq_data_i`, `wr_be` bit k set iff k < lanes (lanes = `rq_groups_i`, 0→8). Then beat_cnt++ and watchdog clears.
  - When a beat arrives with beat_cnt==out_beats-1, go to DONE.
  - If the watchdog reaches TIMEOUT-1 with no beat, set `err` and go to FLUSH.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **abort** (internal input `abort_i`, in, 1; add to port list): from LOAD/RUN go to FLUSH, no `done`.
- **FLUSH**
  - `conv_en_o`=0; writes suppressed.
  - Count FLUSH_CYCLES, then IDLE.
- **Arithmetic:** address sum wraps modulo 2^MAX_ADDR_WIDTH without error.
- **Simultaneous events:**
  - `abort_i` and a final beat in the same cycle: abort wins and the beat is not written.
  - `cmd_valid` in a non-IDLE state is ignored.

## Timing
- **Reset values:** state=IDLE, `cmd_ready`=1, all `cfg_*`=0, `conv_en_o`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_be`=0, `busy`=0, `done`=0, `err`=0.
- **Command to enable:**
  - Handshake at cycle T → `cfg_*` valid at T+1.
  - `conv_en_o` rises at T+2, giving GEMM one full cycle of stable configuration.
- **Write latency:** `rq_valid_i` at cycle C → `wr_en`/`wr_addr`/`wr_data`/`wr_be` registered at C+1, one cycle wide.
- **Completion:**
  - Final beat at C → `conv_en_o` low at C+1, `done` high at C+1.
  - `cmd_ready` returns at C+2.
- **Back-to-back beats:** one per cycle, no bubbles.
- **Reset mid-operation:** asynchronous return to reset values; the partial layer is lost and no `done` is issued.

## Structure
- Shared package `npu_sched_pkg`:
  - state encoding localparams
  - lane-count-to-byte-enable function
  - TIMEOUT and FLUSH_CYCLES defaults
- Natural sub-module: `out_writeback`, containing the address counter, byte-enable generation and write register.
- The FSM, command latch and watchdog stay in the top level.

## Test plan
- **Basic layer:** command with out_beats=4, base=0x100; four beats with groups=0 → writes at 0x100–0x103, `wr_be`=0xFF, `done` one cycle after the 4th beat.
- **Partial lanes:** beat with groups=3, data 0x…AABBCC → `wr_be`=0x07, data passed unchanged.
- **Zero-beat command:** out_beats=0 → `conv_en_o` never rises, `done` at T+2.
- **Watchdog:** no beats for TIMEOUT cycles → `err`=1, FLUSH, `done` never asserted, `cmd_ready` after FLUSH_CYCLES.
- **Abort collision:** abort on the same cycle as the final beat → no write, no `done`, FLUSH entered.
- **Edge cases:**
  - base=2^18-2 with 3 beats → addresses 0x3FFFE, 0x3FFFF, 0x0.
  - Stray beat in IDLE → `err`=1, no write.
